// File: rtl/demux_dispatch_1to2_pkg.sv
// Shared constants for the 1-to-2 handshaked dispatcher: channel indices and default widths.
package demux_dispatch_1to2_pkg;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned CW_DEF = 8;
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;
endpackage

// File: rtl/demux_dispatch_1to2_out_slot.sv
// One output channel: a valid/data holding register plus a saturating delivery counter.
module demux_out_slot
  import demux_dispatch_1to2_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          ready_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [CW-1:0] cnt_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deliver;

  assign deliver = valid_q & ready_i;

  // A load in the same cycle as a delivery reloads the register and keeps it valid.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (deliver) begin
      valid_d = 1'b0;
      if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
    end
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux_dispatch_1to2.sv
// Registered, handshaked 1-to-2 dispatcher with per-channel saturating delivery counts.
// Optional ROUND_ROBIN_EN: target channel comes from an alternating pointer instead of in_sel.
module demux_dispatch_1to2
  import demux_dispatch_1to2_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic          in_sel,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          y0_valid,
  output logic [DW-1:0] y0_data,
  input  logic          y0_ready,
  output logic          y1_valid,
  output logic [DW-1:0] y1_data,
  input  logic          y1_ready,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  logic target_c;
  logic tgt_valid, tgt_ready;
  logic accept;
  logic load0, load1;

`ifdef ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // Strict alternation: the pointer only moves on an accepted word.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = ~ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  assign target_c = ptr_q;
`else
  assign target_c = in_sel;
`endif

  assign tgt_valid = (target_c == CH1) ? y1_valid : y0_valid;
  assign tgt_ready = (target_c == CH1) ? y1_ready : y0_ready;

  // rst_n gating keeps in_ready low for the whole reset window.
  assign in_ready = rst_n & en & (~tgt_valid | tgt_ready);
  assign accept   = in_valid & in_ready;
  assign load0    = accept & (target_c == CH0);
  assign load1    = accept & (target_c == CH1);

  demux_out_slot #(.DW(DW), .CW(CW)) u_slot0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load0),
    .ready_i (y0_ready),
    .data_i  (in_data),
    .valid_o (y0_valid),
    .data_o  (y0_data),
    .cnt_o   (cnt0)
  );

  demux_out_slot #(.DW(DW), .CW(CW)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load1),
    .ready_i (y1_ready),
    .data_i  (in_data),
    .valid_o (y1_valid),
    .data_o  (y1_data),
    .cnt_o   (cnt1)
  );

endmodule
